// File: rtl/flag_controller.sv
// Sequencer for the NZCV flag register: arbitrates ALU writes against interrupt-return
// restores, holds one deferred ALU write, and resolves branch conditions against the
// flags once they have settled.
module flag_controller (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Alu_Valid,
  input  logic       Alu_SetFlags,
  input  logic [3:0] Alu_Flags,
  input  logic       Restore_Req,
  input  logic [3:0] Restore_Flags,
  input  logic       Branch_Req,
  input  logic [3:0] Branch_Cond,
  input  logic [3:0] Out_FR,
  output logic [3:0] In_FR,
  output logic       FR_Ld,
  output logic       Restore_Ack,
  output logic       Branch_Valid,
  output logic       Branch_Taken,
  output logic       Busy
);

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StLoad,
    StSettle,
    StResolve
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] in_fr_q, in_fr_d;
  logic       src_restore_q, src_restore_d;
  logic [3:0] cond_q, cond_d;
  logic       pend_valid_q, pend_valid_d;
  logic [3:0] pend_flags_q, pend_flags_d;

  logic       alu_wr;
  logic       cond_hit;

  assign alu_wr = Alu_Valid & Alu_SetFlags;

  // Evaluate a condition code against an NZCV value (ARM ordering).
  function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    logic res;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    res = 1'b0;
    unique case (code)
      4'd0:  res = z;
      4'd1:  res = ~z;
      4'd2:  res = c;
      4'd3:  res = ~c;
      4'd4:  res = n;
      4'd5:  res = ~n;
      4'd6:  res = v;
      4'd7:  res = ~v;
      4'd8:  res = c & ~z;
      4'd9:  res = ~c | z;
      4'd10: res = (n == v);
      4'd11: res = (n != v);
      4'd12: res = ~z & (n == v);
      4'd13: res = z | (n != v);
      4'd14: res = 1'b1;
      4'd15: res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Next-state logic: state, latched load value, branch code and pending slot.
  always_comb begin
    state_d       = state_q;
    in_fr_d       = in_fr_q;
    src_restore_d = src_restore_q;
    cond_d        = cond_q;
    pend_valid_d  = pend_valid_q;
    pend_flags_d  = pend_flags_q;

    // Any flag-setting ALU result outside IDLE is deferred; last writer wins.
    if (alu_wr && (state_q != StIdle)) begin
      pend_valid_d = 1'b1;
      pend_flags_d = Alu_Flags;
    end

    unique case (state_q)
      StClear: begin
        state_d = StIdle;
      end
      StIdle: begin
        if (Restore_Req) begin
          in_fr_d       = Restore_Flags;
          src_restore_d = 1'b1;
          state_d       = StLoad;
          // A concurrent ALU write waits in the slot until the restore has settled.
          if (alu_wr) begin
            pend_valid_d = 1'b1;
            pend_flags_d = Alu_Flags;
          end
        end else if (alu_wr || pend_valid_q) begin
          // The fresh ALU value is newer than anything held in the slot.
          in_fr_d       = alu_wr ? Alu_Flags : pend_flags_q;
          src_restore_d = 1'b0;
          pend_valid_d  = 1'b0;
          state_d       = StLoad;
        end else if (Branch_Req) begin
          cond_d  = Branch_Cond;
          state_d = StResolve;
        end
      end
      StLoad: begin
        state_d = StSettle;
      end
      StSettle: begin
        state_d = StIdle;
      end
      StResolve: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  // State register with synchronous reset; reset drops any pending or in-flight work.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= StClear;
      in_fr_q       <= 4'b0000;
      src_restore_q <= 1'b0;
      cond_q        <= 4'd0;
      pend_valid_q  <= 1'b0;
      pend_flags_q  <= 4'b0000;
    end else begin
      state_q       <= state_d;
      in_fr_q       <= in_fr_d;
      src_restore_q <= src_restore_d;
      cond_q        <= cond_d;
      pend_valid_q  <= pend_valid_d;
      pend_flags_q  <= pend_flags_d;
    end
  end

  // Moore output decode; CLEAR loads the zeroed in_fr_q so the flag register clears.
  always_comb begin
    cond_hit     = eval_cond(cond_q, Out_FR);
    In_FR        = in_fr_q;
    FR_Ld        = (state_q == StClear) || (state_q == StLoad);
    Restore_Ack  = (state_q == StLoad) && src_restore_q;
    Branch_Valid = (state_q == StResolve);
    Branch_Taken = (state_q == StResolve) && cond_hit;
    Busy         = (state_q != StIdle) || pend_valid_q;
  end

endmodule

// File: tb/tb_flag_controller.sv
// Self-checking bench for flag_controller: directed scenarios plus a randomized
// transaction stream checked against a transaction-level flag model.
module tb_flag_controller;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Alu_Valid, Alu_SetFlags;
  logic [3:0] Alu_Flags;
  logic       Restore_Req;
  logic [3:0] Restore_Flags;
  logic       Branch_Req;
  logic [3:0] Branch_Cond;
  logic [3:0] Out_FR;
  logic [3:0] In_FR;
  logic       FR_Ld, Restore_Ack, Branch_Valid, Branch_Taken, Busy;

  int checks = 0;
  int errors = 0;

  flag_controller dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Alu_Valid    (Alu_Valid),
    .Alu_SetFlags (Alu_SetFlags),
    .Alu_Flags    (Alu_Flags),
    .Restore_Req  (Restore_Req),
    .Restore_Flags(Restore_Flags),
    .Branch_Req   (Branch_Req),
    .Branch_Cond  (Branch_Cond),
    .Out_FR       (Out_FR),
    .In_FR        (In_FR),
    .FR_Ld        (FR_Ld),
    .Restore_Ack  (Restore_Ack),
    .Branch_Valid (Branch_Valid),
    .Branch_Taken (Branch_Taken),
    .Busy         (Busy)
  );

  always #5 Clk = ~Clk;

  // The flag register this block drives.
  initial Out_FR = 4'b0000;
  always @(posedge Clk) if (FR_Ld) Out_FR <= In_FR;

  // Condition model: even codes test a predicate, odd codes its inverse.
  function automatic bit cond_ref(input int code, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code / 2)
      0: base = z;
      1: base = c;
      2: base = n;
      3: base = v;
      4: base = c && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (code % 2 == 1) ? !base : base;
  endfunction

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs;
    Alu_Valid = 0; Alu_SetFlags = 0; Alu_Flags = 0;
    Restore_Req = 0; Restore_Flags = 0; Branch_Req = 0; Branch_Cond = 0;
  endtask

  // Waits (bounded) for Busy to drop; reports whether it did.
  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while (Busy !== 1'b0 && n < 30) begin
      step;
      n++;
    end
    ok = (Busy === 1'b0);
  endtask

  task automatic test_reset;
    Reset = 1;
    idle_inputs;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++;
      if (FR_Ld !== 1'b1 || In_FR !== 4'b0000 || Busy !== 1'b1 || Restore_Ack !== 1'b0 ||
          Branch_Valid !== 1'b0 || Branch_Taken !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: FR_Ld=%b In_FR=%b Busy=%b Ack=%b BV=%b BT=%b, required 1 0000 1 0 0 0",
                 i, FR_Ld, In_FR, Busy, Restore_Ack, Branch_Valid, Branch_Taken);
      end
    end
    Reset = 0;
    step;
    step;
    checks++;
    if (Busy !== 1'b0 || FR_Ld !== 1'b0 || Out_FR !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: Busy=%b FR_Ld=%b Out_FR=%b, required 0 0 0000",
               Busy, FR_Ld, Out_FR);
    end
  endtask

  // ALU write then branch on the following cycle; branch must wait for the settled flags.
  task automatic test_alu_branch(input logic [3:0] f, input logic [3:0] code, input bit exp);
    Alu_Valid = 1; Alu_SetFlags = 1; Alu_Flags = f;
    step;  // t+1
    Alu_Valid = 0; Alu_SetFlags = 0;
    checks++;
    if (FR_Ld !== 1'b1 || In_FR !== f) begin
      errors++;
      $display("FAIL alu_load: FR_Ld=%b In_FR=%b, required 1 %b", FR_Ld, In_FR, f);
    end
    Branch_Req = 1; Branch_Cond = code;
    step;  // t+2
    checks++;
    if (Out_FR !== f || Branch_Valid !== 1'b0 || FR_Ld !== 1'b0) begin
      errors++;
      $display("FAIL alu_settle: Out_FR=%b BV=%b FR_Ld=%b, required %b 0 0",
               Out_FR, Branch_Valid, FR_Ld, f);
    end
    step;  // t+3
    checks++;
    if (Branch_Valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_early: Branch_Valid=%b, required 0", Branch_Valid);
    end
    step;  // t+4
    checks++;
    if (Branch_Valid !== 1'b1 || Branch_Taken !== exp) begin
      errors++;
      $display("FAIL branch_after_alu code=%0d: BV=%b BT=%b, required 1 %b",
               code, Branch_Valid, Branch_Taken, exp);
    end
    Branch_Req = 0;
    step;
  endtask

  task automatic test_cond_sweep;
    logic [15:0] taken_mask;
    bit ok;
    taken_mask = 16'h565A;  // NE CC MI VS LS GE GT AL with N=1 V=1
    Alu_Valid = 1; Alu_SetFlags = 1; Alu_Flags = 4'b1001;
    step;
    Alu_Valid = 0; Alu_SetFlags = 0;
    wait_idle(ok);
    for (int c = 0; c < 16; c++) begin
      Branch_Req = 1; Branch_Cond = 4'(c);
      step;
      checks++;
      if (Branch_Valid !== 1'b1 || Branch_Taken !== taken_mask[c] ||
          Branch_Taken !== cond_ref(c, 4'b1001)) begin
        errors++;
        $display("FAIL cond_sweep code=%0d: BV=%b BT=%b, required 1 %b",
                 c, Branch_Valid, Branch_Taken, taken_mask[c]);
      end
      Branch_Req = 0;
      step;
    end
  endtask

  task automatic test_restore_with_alu;
    Restore_Req = 1; Restore_Flags = 4'b1010;
    Alu_Valid = 1; Alu_SetFlags = 1; Alu_Flags = 4'b0011;
    step;  // t+1
    Alu_Valid = 0; Alu_SetFlags = 0;
    checks++;
    if (Restore_Ack !== 1'b1 || FR_Ld !== 1'b1 || In_FR !== 4'b1010) begin
      errors++;
      $display("FAIL restore_load: Ack=%b FR_Ld=%b In_FR=%b, required 1 1 1010",
               Restore_Ack, FR_Ld, In_FR);
    end
    Restore_Req = 0;
    step;  // t+2
    checks++;
    if (Out_FR !== 4'b1010 || Restore_Ack !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL restore_settle: Out_FR=%b Ack=%b Busy=%b, required 1010 0 1",
               Out_FR, Restore_Ack, Busy);
    end
    step;  // t+3 idle, slot full
    step;  // t+4
    checks++;
    if (FR_Ld !== 1'b1 || In_FR !== 4'b0011 || Restore_Ack !== 1'b0) begin
      errors++;
      $display("FAIL restore_pending_load: FR_Ld=%b In_FR=%b Ack=%b, required 1 0011 0",
               FR_Ld, In_FR, Restore_Ack);
    end
    step;
    step;
    checks++;
    if (Out_FR !== 4'b0011 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL restore_final: Out_FR=%b Busy=%b, required 0011 0", Out_FR, Busy);
    end
  endtask

  // Pulses on t, t+1, t+2: the middle one is overwritten in the slot.
  task automatic test_back_to_back;
    logic [3:0] vals [3];
    logic [6:0] ld_exp;
    logic [6:0] busy_exp;
    vals[0] = 4'b0001; vals[1] = 4'b0010; vals[2] = 4'b0100;
    ld_exp   = 7'b0010010;  // bit k = FR_Ld in cycle t+k
    busy_exp = 7'b0111110;
    for (int k = 0; k < 7; k++) begin
      if (k < 3) begin
        Alu_Valid = 1; Alu_SetFlags = 1; Alu_Flags = vals[k];
      end else begin
        Alu_Valid = 0; Alu_SetFlags = 0;
      end
      if (k > 0) begin
        checks++;
        if (FR_Ld !== ld_exp[k] || Busy !== busy_exp[k]) begin
          errors++;
          $display("FAIL back_to_back t+%0d: FR_Ld=%b Busy=%b, required %b %b",
                   k, FR_Ld, Busy, ld_exp[k], busy_exp[k]);
        end
        if (k == 1 || k == 4) begin
          checks++;
          if (In_FR !== ((k == 1) ? 4'b0001 : 4'b0100)) begin
            errors++;
            $display("FAIL back_to_back_data t+%0d: In_FR=%b, required %b",
                     k, In_FR, (k == 1) ? 4'b0001 : 4'b0100);
          end
        end
      end
      step;
    end
    checks++;
    if (Out_FR !== 4'b0100) begin
      errors++;
      $display("FAIL back_to_back_final: Out_FR=%b, required 0100", Out_FR);
    end
  endtask

  task automatic test_reset_mid;
    int loads;
    Alu_Valid = 1; Alu_SetFlags = 1; Alu_Flags = 4'b0101;
    step;  // LOAD
    Alu_Flags = 4'b0110;
    step;  // SETTLE with 0110 pending
    Alu_Valid = 0; Alu_SetFlags = 0;
    Reset = 1;
    step;
    checks++;
    if (FR_Ld !== 1'b1 || In_FR !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_clear: FR_Ld=%b In_FR=%b, required 1 0000", FR_Ld, In_FR);
    end
    step;
    Reset = 0;
    step;
    loads = 0;
    for (int i = 0; i < 6; i++) begin
      if (FR_Ld === 1'b1) loads++;
      step;
    end
    checks++;
    if (loads != 0 || Out_FR !== 4'b0000 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_discard: loads=%0d Out_FR=%b Busy=%b, required 0 0000 0",
               loads, Out_FR, Busy);
    end
  endtask

  task automatic test_random;
    logic [3:0] model;
    logic [3:0] a, r;
    int op, code, n;
    bit ok;
    model = Out_FR === 4'b0000 ? 4'b0000 : 4'bxxxx;
    for (int it = 0; it < 150; it++) begin
      op = $urandom_range(0, 4);
      a = 4'($urandom_range(0, 15));
      r = 4'($urandom_range(0, 15));
      code = $urandom_range(0, 15);
      case (op)
        0, 1: begin
          Alu_Valid = 1; Alu_SetFlags = (op == 0); Alu_Flags = a;
          step;
          Alu_Valid = 0; Alu_SetFlags = 0;
          checks++;
          if (FR_Ld !== (op == 0)) begin
            errors++;
            $display("FAIL rand_alu_ld it=%0d setflags=%0d: FR_Ld=%b, required %b",
                     it, op == 0, FR_Ld, op == 0);
          end
          if (op == 0) model = a;
        end
        2, 3: begin
          Restore_Req = 1; Restore_Flags = r;
          if (op == 3) begin
            Alu_Valid = 1; Alu_SetFlags = 1; Alu_Flags = a;
          end
          n = 0;
          do begin
            step;
            Alu_Valid = 0; Alu_SetFlags = 0;
            n++;
          end while (Restore_Ack !== 1'b1 && n < 10);
          checks++;
          if (Restore_Ack !== 1'b1 || n != 1 || In_FR !== r || FR_Ld !== 1'b1) begin
            errors++;
            $display("FAIL rand_restore it=%0d: Ack=%b latency=%0d In_FR=%b, required 1 1 %b",
                     it, Restore_Ack, n, In_FR, r);
          end
          Restore_Req = 0;
          model = (op == 3) ? a : r;
        end
        default: begin
          Branch_Req = 1; Branch_Cond = 4'(code);
          n = 0;
          do begin
            step;
            n++;
          end while (Branch_Valid !== 1'b1 && n < 10);
          checks++;
          if (Branch_Valid !== 1'b1 || n != 1 || Branch_Taken !== cond_ref(code, model)) begin
            errors++;
            $display("FAIL rand_branch it=%0d code=%0d flags=%b: BV=%b latency=%0d BT=%b, required 1 1 %b",
                     it, code, model, Branch_Valid, n, Branch_Taken, cond_ref(code, model));
          end
          Branch_Req = 0;
        end
      endcase
      wait_idle(ok);
      checks++;
      if (!ok || Out_FR !== model) begin
        errors++;
        $display("FAIL rand_flags it=%0d op=%0d: idle=%b Out_FR=%b, required 1 %b",
                 it, op, ok, Out_FR, model);
      end
    end
  endtask

  // Bounded run: abort loudly rather than hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    idle_inputs;
    Reset = 1;
    test_reset;
    test_alu_branch(4'b0100, 4'd0, 1'b1);
    test_alu_branch(4'b0100, 4'd1, 1'b0);
    test_cond_sweep;
    test_restore_with_alu;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
